// File: rtl/fadd_tree_packer.sv
// fadd_tree_packer: serialises scalar elements into SHAPE_K-lane vectors for the fadd_tree
// reduction tree. The control tags and rounding mode are captured with the first element of each
// vector and travel with it. An element flagged elem_last_i closes the vector early; the unused
// upper lanes are zero-filled (+0.0) so the tree sums only real lanes.
//
// Build option:
//   FADD_PACK_DBUF_EN  when defined, two ping-pong vector buffers let gathering continue while
//                      the other buffer waits for the downstream handshake. When undefined, a
//                      single buffer alternates between gathering and holding.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   elem_i/elem_last_i              input scalar and early-close flag
//   elem_valid_i/elem_ready_o       input handshake
//   rm_i, ctrl_*_i                  tags, sampled with the first element of a vector
//   data_o                          packed vector, lane j at [(j+1)*ELEMENT_WIDTH-1 -: ELEMENT_WIDTH]
//   lane_cnt_o                      number of real lanes in data_o (1..SHAPE_K)
//   out_valid_o/out_ready_i         output handshake (connects to the tree's input port)
//   rm_o, ctrl_*_o                  tags of the presented vector
module fadd_tree_packer #(
    parameter int unsigned SHAPE_K       = 8,
    parameter int unsigned ELEMENT_WIDTH = 9,
    parameter int unsigned CTRL_C_WIDTH  = 16,
    parameter int unsigned DEPTH_WARP    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ELEMENT_WIDTH-1:0]           elem_i,
    input  logic                               elem_last_i,
    input  logic                               elem_valid_i,
    output logic                               elem_ready_o,
    input  logic [2:0]                         rm_i,
    input  logic [CTRL_C_WIDTH-1:0]            ctrl_c_i,
    input  logic [2:0]                         ctrl_rm_i,
    input  logic [7:0]                         ctrl_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]              ctrl_warpid_i,
    output logic [SHAPE_K*ELEMENT_WIDTH-1:0]   data_o,
    output logic [$clog2(SHAPE_K+1)-1:0]       lane_cnt_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [2:0]                         rm_o,
    output logic [CTRL_C_WIDTH-1:0]            ctrl_c_o,
    output logic [2:0]                         ctrl_rm_o,
    output logic [7:0]                         ctrl_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]              ctrl_warpid_o
);

    localparam int unsigned CntW = $clog2(SHAPE_K);
    localparam int unsigned LcW  = $clog2(SHAPE_K + 1);
`ifdef FADD_PACK_DBUF_EN
    localparam int unsigned NumBuf = 2;
`else
    localparam int unsigned NumBuf = 1;
`endif

    // Each buffer is either being filled or holding a closed vector for the tree.
    typedef enum logic {
        StGather = 1'b0,
        StHold   = 1'b1
    } buf_state_e;

    buf_state_e                 state_q [NumBuf];
    buf_state_e                 state_d [NumBuf];
    logic [ELEMENT_WIDTH-1:0]   lane_q  [NumBuf][SHAPE_K];
    logic [ELEMENT_WIDTH-1:0]   lane_d  [NumBuf][SHAPE_K];
    logic [LcW-1:0]             lcnt_q  [NumBuf];
    logic [LcW-1:0]             lcnt_d  [NumBuf];
    logic [2:0]                 rm_q    [NumBuf];
    logic [2:0]                 rm_d    [NumBuf];
    logic [CTRL_C_WIDTH-1:0]    cc_q    [NumBuf];
    logic [CTRL_C_WIDTH-1:0]    cc_d    [NumBuf];
    logic [2:0]                 crm_q   [NumBuf];
    logic [2:0]                 crm_d   [NumBuf];
    logic [7:0]                 idxw_q  [NumBuf];
    logic [7:0]                 idxw_d  [NumBuf];
    logic [DEPTH_WARP-1:0]      wid_q   [NumBuf];
    logic [DEPTH_WARP-1:0]      wid_d   [NumBuf];

    logic [CntW-1:0] cnt_q, cnt_d;
    // Write/read buffer selectors; both stay at 0 in the single-buffer build.
    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;

    logic accept;
    logic closing;
    logic handshake;

    // Ready depends only on the registered state of the buffer being written; with ping-pong
    // ordering that buffer is busy exactly when every buffer holds a closed vector.
    assign elem_ready_o = (state_q[wr_sel_q] == StGather);
    assign out_valid_o  = (state_q[rd_sel_q] == StHold);
    assign accept       = elem_valid_i & elem_ready_o;
    assign closing      = accept & (elem_last_i | (cnt_q == CntW'(SHAPE_K - 1)));
    assign handshake    = out_valid_o & out_ready_i;

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        lcnt_d   = lcnt_q;
        rm_d     = rm_q;
        cc_d     = cc_q;
        crm_d    = crm_q;
        idxw_d   = idxw_q;
        wid_d    = wid_q;
        cnt_d    = cnt_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;

        // The write and read buffers are never the same one when both events fire, because one
        // must be gathering and the other holding.
        if (accept) begin
            lane_d[wr_sel_q][cnt_q] = elem_i;
            if (cnt_q == '0) begin
                rm_d[wr_sel_q]   = rm_i;
                cc_d[wr_sel_q]   = ctrl_c_i;
                crm_d[wr_sel_q]  = ctrl_rm_i;
                idxw_d[wr_sel_q] = ctrl_reg_idxw_i;
                wid_d[wr_sel_q]  = ctrl_warpid_i;
            end
            if (closing) begin
                // Zero-fill lanes above the closing element so a short vector sums correctly.
                for (int j = 0; j < SHAPE_K; j++) begin
                    if (j > int'(cnt_q)) begin
                        lane_d[wr_sel_q][j] = '0;
                    end
                end
                lcnt_d[wr_sel_q]  = LcW'(cnt_q) + LcW'(1);
                state_d[wr_sel_q] = StHold;
                cnt_d             = '0;
`ifdef FADD_PACK_DBUF_EN
                wr_sel_d          = ~wr_sel_q;
`endif
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        if (handshake) begin
            state_d[rd_sel_q] = StGather;
            for (int j = 0; j < SHAPE_K; j++) begin
                lane_d[rd_sel_q][j] = '0;
            end
`ifdef FADD_PACK_DBUF_EN
            rd_sel_d = ~rd_sel_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NumBuf; b++) begin
                state_q[b] <= StGather;
                lcnt_q[b]  <= '0;
                rm_q[b]    <= '0;
                cc_q[b]    <= '0;
                crm_q[b]   <= '0;
                idxw_q[b]  <= '0;
                wid_q[b]   <= '0;
                for (int j = 0; j < SHAPE_K; j++) begin
                    lane_q[b][j] <= '0;
                end
            end
            cnt_q    <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            lcnt_q   <= lcnt_d;
            rm_q     <= rm_d;
            cc_q     <= cc_d;
            crm_q    <= crm_d;
            idxw_q   <= idxw_d;
            wid_q    <= wid_d;
            cnt_q    <= cnt_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Outputs are gated by out_valid_o so a buffer that is still being filled never leaks
    // partial lanes or tags onto the tree interface.
    always_comb begin
        data_o          = '0;
        lane_cnt_o      = '0;
        rm_o            = '0;
        ctrl_c_o        = '0;
        ctrl_rm_o       = '0;
        ctrl_reg_idxw_o = '0;
        ctrl_warpid_o   = '0;
        if (out_valid_o) begin
            for (int j = 0; j < SHAPE_K; j++) begin
                data_o[j*ELEMENT_WIDTH +: ELEMENT_WIDTH] = lane_q[rd_sel_q][j];
            end
            lane_cnt_o      = lcnt_q[rd_sel_q];
            rm_o            = rm_q[rd_sel_q];
            ctrl_c_o        = cc_q[rd_sel_q];
            ctrl_rm_o       = crm_q[rd_sel_q];
            ctrl_reg_idxw_o = idxw_q[rd_sel_q];
            ctrl_warpid_o   = wid_q[rd_sel_q];
        end
    end

endmodule

// File: tb/tb_fadd_tree_packer.sv
// Self-checking bench for fadd_tree_packer. A queue-based model tracks the partial vector and
// the closed vectors waiting for the tree; every cycle the DUT handshake signals and the
// presented vector are compared against it.
module tb_fadd_tree_packer;

    localparam int K  = 8;
    localparam int EW = 9;
`ifdef FADD_PACK_DBUF_EN
    localparam int NB       = 2;
    localparam int TPUT_EXP = 33;
`else
    localparam int NB       = 1;
    localparam int TPUT_EXP = 36;
`endif

    logic            clk;
    logic            rst_n;
    logic [EW-1:0]   elem;
    logic            elem_last;
    logic            elem_valid;
    logic            elem_ready;
    logic [2:0]      rm;
    logic [15:0]     ctrl_c;
    logic [2:0]      ctrl_rm;
    logic [7:0]      ctrl_idxw;
    logic [3:0]      ctrl_wid;
    logic [K*EW-1:0] data;
    logic [3:0]      lane_cnt;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      rm_out;
    logic [15:0]     ctrl_c_out;
    logic [2:0]      ctrl_rm_out;
    logic [7:0]      ctrl_idxw_out;
    logic [3:0]      ctrl_wid_out;

    fadd_tree_packer #(
        .SHAPE_K      (K),
        .ELEMENT_WIDTH(EW),
        .CTRL_C_WIDTH (16),
        .DEPTH_WARP   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .elem_i         (elem),
        .elem_last_i    (elem_last),
        .elem_valid_i   (elem_valid),
        .elem_ready_o   (elem_ready),
        .rm_i           (rm),
        .ctrl_c_i       (ctrl_c),
        .ctrl_rm_i      (ctrl_rm),
        .ctrl_reg_idxw_i(ctrl_idxw),
        .ctrl_warpid_i  (ctrl_wid),
        .data_o         (data),
        .lane_cnt_o     (lane_cnt),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .rm_o           (rm_out),
        .ctrl_c_o       (ctrl_c_out),
        .ctrl_rm_o      (ctrl_rm_out),
        .ctrl_reg_idxw_o(ctrl_idxw_out),
        .ctrl_warpid_o  (ctrl_wid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [K*EW-1:0] data;
        logic [3:0]      lcnt;
        logic [2:0]      rm;
        logic [15:0]     cc;
        logic [2:0]      crm;
        logic [7:0]      idx;
        logic [3:0]      wid;
    } vec_t;

    vec_t          pend[$];   // closed vectors not yet taken by the tree, in close order
    logic [EW-1:0] part[$];   // elements of the vector being gathered
    vec_t          part_tag;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int hs_cnt   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, then advance the model.
    task automatic step(input logic v, input logic [EW-1:0] e, input logic l, input logic ordy,
                        input logic [3:0] wid);
        logic exp_ready, exp_valid;
        vec_t nv;
        elem_valid = v;
        elem       = e;
        elem_last  = l;
        out_ready  = ordy;
        ctrl_wid   = wid;
        rm         = 3'($urandom);
        ctrl_c     = 16'($urandom);
        ctrl_rm    = 3'($urandom);
        ctrl_idxw  = 8'($urandom);
        @(negedge clk);
        exp_ready = (pend.size() < NB);
        exp_valid = (pend.size() > 0);
        check("elem_ready", 128'(elem_ready), 128'(exp_ready));
        check("out_valid", 128'(out_valid), 128'(exp_valid));
        if (exp_valid) begin
            check("data", 128'(data), 128'(pend[0].data));
            check("lane_cnt", 128'(lane_cnt), 128'(pend[0].lcnt));
            check("tags", {rm_out, ctrl_c_out, ctrl_rm_out, ctrl_idxw_out, ctrl_wid_out},
                  {pend[0].rm, pend[0].cc, pend[0].crm, pend[0].idx, pend[0].wid});
        end
        if (exp_valid && ordy) begin
            void'(pend.pop_front());
            hs_cnt++;
        end
        if (v && exp_ready) begin
            acc_cnt++;
            if (part.size() == 0) begin
                part_tag.rm  = rm;
                part_tag.cc  = ctrl_c;
                part_tag.crm = ctrl_rm;
                part_tag.idx = ctrl_idxw;
                part_tag.wid = wid;
            end
            part.push_back(e);
            if (l || part.size() == K) begin
                nv      = part_tag;
                nv.data = '0;
                foreach (part[j]) nv.data[j*EW +: EW] = part[j];
                nv.lcnt = 4'(part.size());
                pend.push_back(nv);
                part.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Close any partial vector and let all pending vectors drain.
    task automatic drain();
        int guard = 0;
        while (part.size() != 0 && guard < 20) begin
            step(1'b1, 9'h1FF, 1'b1, 1'b1, 4'h0);
            guard++;
        end
        for (int i = 0; i < NB + 3; i++) step(1'b0, '0, 1'b0, 1'b1, 4'h0);
        check("drained", 128'(pend.size() + part.size()), 128'(0));
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        elem_valid = 1'b0;
        elem       = '0;
        elem_last  = 1'b0;
        out_ready  = 1'b0;
        rm         = '0;
        ctrl_c     = '0;
        ctrl_rm    = '0;
        ctrl_idxw  = '0;
        ctrl_wid   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(data), 128'(0));
        check("rst_lcnt", 128'(lane_cnt), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full vector 1..8.
        for (int i = 1; i <= K; i++) step(1'b1, 9'(i), 1'b0, 1'b1, 4'h2);
        drain();

        // Short vector closed by elem_last on the third element.
        step(1'b1, 9'h0A, 1'b0, 1'b1, 4'h1);
        step(1'b1, 9'h0B, 1'b0, 1'b1, 4'h1);
        step(1'b1, 9'h0C, 1'b1, 1'b1, 4'h1);
        drain();

        // Single-element vector; elem_last while invalid must be ignored.
        step(1'b0, 9'h55, 1'b1, 1'b1, 4'h0);
        step(1'b1, 9'h33, 1'b1, 1'b1, 4'h4);
        drain();

        // Backpressure: full vector then downstream stalled for 5 cycles.
        for (int i = 0; i < K; i++) step(1'b1, 9'(i + 20), 1'b0, 1'b0, 4'h6);
        for (int i = 0; i < 5; i++) step(1'b1, 9'(i + 40), 1'b0, 1'b0, 4'h9);
        drain();

        // Warp id captured from the first element only, then the next vector's own first.
        step(1'b1, 9'h001, 1'b0, 1'b1, 4'd3);
        for (int i = 1; i < K; i++) step(1'b1, 9'(i), 1'b0, 1'b1, 4'd7);
        step(1'b1, 9'h002, 1'b0, 1'b1, 4'd5);
        for (int i = 1; i < K; i++) step(1'b1, 9'(i + 8), 1'b0, 1'b1, 4'd7);
        drain();

        // Reset after 4 accepts discards the partial vector.
        for (int i = 0; i < 4; i++) step(1'b1, 9'(i + 100), 1'b0, 1'b1, 4'h8);
        elem_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("arst_valid", 128'(out_valid), 128'(0));
        check("arst_data", 128'(data), 128'(0));
        check("arst_tags", {lane_cnt, ctrl_wid_out, ctrl_c_out}, 128'(0));
        pend.delete();
        part.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < K; i++) step(1'b1, 9'(i + 200), 1'b0, 1'b1, 4'hA);
        drain();

        // Throughput: 4 back-to-back vectors with valid and ready held high.
        acc_cnt = 0;
        hs_cnt  = 0;
        n       = 0;
        while (hs_cnt < 4 && n < 80) begin
            step(acc_cnt < 4 * K, 9'($urandom), 1'b0, 1'b1, 4'($urandom));
            n++;
        end
        check("tput_cycles", 128'(n), 128'(TPUT_EXP));
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 2) != 0, 4'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
